// File: rtl/rle_channel_arbiter_if.sv
// Output handshake bundle between the channel arbiter and the serial sender.
// The arbiter presents a word with its channel index; the sender acknowledges it.
interface rle_channel_arbiter_if #(
    parameter int P  = 16,
    parameter int CW = 4
);
    logic [P-1:0]  word_out;
    logic [CW-1:0] ch_out;
    logic          valid_out;
    logic          ack_in;

    modport master (
        output word_out,
        output ch_out,
        output valid_out,
        input  ack_in
    );

    modport slave (
        input  word_out,
        input  ch_out,
        input  valid_out,
        output ack_in
    );
endinterface

// File: rtl/rle_channel_arbiter.sv
// Captures per-channel RLE words into holding registers and grants the single
// output port round-robin, counting words lost to overrun.
//
// state | meaning
// EMPTY | output register idle, valid_out=0
// FULL  | output register holds a word awaiting ack_in
module rle_channel_arbiter #(
    parameter int N  = 16,
    parameter int P  = 16,
    parameter int CW = 4
) (
    input  logic                  rdclk,
    input  logic                  nreset,
    input  logic                  en,
    input  logic [N*P-1:0]        word_in,
    input  logic [N-1:0]          ready_in,
    input  logic                  clr_stat,
    rle_channel_arbiter_if.master sender,
    output logic [N-1:0]          overflow,
    output logic [15:0]           drop_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state;
    state_t        state_next;

    logic [P-1:0]  hold [N];
    logic [N-1:0]  pend;
    logic [N-1:0]  pend_next;
    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_next;
    logic [P-1:0]  word_reg;
    logic [CW-1:0] ch_reg;

    logic [CW-1:0] sel;
    logic          found;
    logic          do_grant;
    logic [N-1:0]  grant_mask;
    logic [N-1:0]  capture;
    logic [N-1:0]  overrun;
    logic [4:0]    n_over;
    logic [15:0]   drop_base;
    logic [16:0]   drop_sum;
    logic [15:0]   drop_next;
    logic [N-1:0]  ovf_next;

    // Rotating search starting at ptr; the first pending channel wins.
    always_comb begin
        logic [CW:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (CW+1)'(k);
            if (idx >= (CW+1)'(N)) begin
                idx = idx - (CW+1)'(N);
            end
            if (!found && pend[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    assign do_grant = en && found && ((state == EMPTY) || sender.ack_in);
    assign ptr_next = (sel == CW'(N-1)) ? '0 : sel + 1'b1;

    // A capture onto a pending channel is legal only if that channel is being
    // granted on the same edge, since the old word leaves as the new one lands.
    always_comb begin
        grant_mask = '0;
        capture    = '0;
        overrun    = '0;
        n_over     = '0;
        for (int i = 0; i < N; i++) begin
            grant_mask[i] = do_grant && (sel == CW'(i));
            if (en && ready_in[i]) begin
                if (pend[i] && !grant_mask[i]) begin
                    overrun[i] = 1'b1;
                end else begin
                    capture[i] = 1'b1;
                end
            end
            n_over = n_over + 5'(overrun[i]);
        end
        pend_next = (pend & ~grant_mask) | capture;
    end

    // Clear first, then this cycle's overruns, so a same-edge overrun survives.
    always_comb begin
        drop_base = clr_stat ? 16'd0 : drop_cnt;
        drop_sum  = {1'b0, drop_base} + 17'(n_over);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        ovf_next  = (clr_stat ? '0 : overflow) | overrun;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (do_grant) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (sender.ack_in && !do_grant) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge rdclk or negedge nreset) begin
        if (!nreset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge rdclk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                hold[i] <= '0;
            end
            pend     <= '0;
            ptr      <= '0;
            word_reg <= '0;
            ch_reg   <= '0;
            overflow <= '0;
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (capture[i]) begin
                    hold[i] <= word_in[i*P +: P];
                end
            end
            pend <= pend_next;
            if (do_grant) begin
                word_reg <= hold[sel];
                ch_reg   <= sel;
                ptr      <= ptr_next;
            end
            overflow <= ovf_next;
            drop_cnt <= drop_next;
        end
    end

    assign sender.word_out  = word_reg;
    assign sender.ch_out    = ch_reg;
    assign sender.valid_out = (state == FULL);

endmodule

// File: tb/tb_rle_channel_arbiter.sv
// Directed bench for rle_channel_arbiter: a transaction-level model of the
// channel holding registers and output port, checked every cycle, plus literals.
module tb_rle_channel_arbiter;
    localparam int N  = 16;
    localparam int P  = 16;
    localparam int CW = 4;

    logic           rdclk    = 1'b0;
    logic           nreset   = 1'b0;
    logic           en       = 1'b1;
    logic           clr_stat = 1'b0;
    logic [N*P-1:0] word_in  = '0;
    logic [N-1:0]   ready_in = '0;
    logic [N-1:0]   overflow;
    logic [15:0]    drop_cnt;

    rle_channel_arbiter_if #(.P(P), .CW(CW)) bus ();

    rle_channel_arbiter #(.N(N), .P(P), .CW(CW)) dut (
        .rdclk    (rdclk),
        .nreset   (nreset),
        .en       (en),
        .word_in  (word_in),
        .ready_in (ready_in),
        .clr_stat (clr_stat),
        .sender   (bus),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 rdclk = ~rdclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: what each channel is still holding, and what sits on the port.
    logic [P-1:0] m_hold [N];
    logic [N-1:0] m_pend;
    int           m_ptr;
    bit           m_valid;
    logic [P-1:0] m_word;
    int           m_ch;
    logic [N-1:0] m_ovf;
    int           m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_hold[i] = '0;
        m_pend  = '0;
        m_ptr   = 0;
        m_valid = 0;
        m_word  = '0;
        m_ch    = 0;
        m_ovf   = '0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        bit           grant;
        int           sel;
        int           nover;
        logic [N-1:0] ovr;
        logic [N-1:0] cap;
        sel   = -1;
        nover = 0;
        ovr   = '0;
        cap   = '0;
        grant = en && (m_pend != 0) && (!m_valid || bus.ack_in);
        if (grant) begin
            for (int j = 0; j < N; j++) begin
                if (sel < 0 && m_pend[(m_ptr + j) % N]) sel = (m_ptr + j) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && ready_in[i]) begin
                if (m_pend[i] && i != sel) begin
                    ovr[i] = 1'b1;
                    nover++;
                end else begin
                    cap[i] = 1'b1;
                end
            end
        end
        if (grant) begin
            m_word      = m_hold[sel];
            m_ch        = sel;
            m_pend[sel] = 1'b0;
            m_ptr       = (sel + 1) % N;
            m_valid     = 1;
        end else if (m_valid && bus.ack_in) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (cap[i]) begin
                m_hold[i] = word_in[i*P +: P];
                m_pend[i] = 1'b1;
            end
        end
        if (clr_stat) begin
            m_ovf  = '0;
            m_drop = 0;
        end
        m_ovf  = m_ovf | ovr;
        m_drop = (m_drop + nover > 65535) ? 65535 : m_drop + nover;
    endtask

    task automatic compare_all();
        check("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
        check("word_out", {16'd0, bus.word_out}, {16'd0, m_word});
        check("ch_out", {28'd0, bus.ch_out}, m_ch);
        check("overflow", {16'd0, overflow}, {16'd0, m_ovf});
        check("drop_cnt", {16'd0, drop_cnt}, m_drop);
    endtask

    task automatic tick();
        @(posedge rdclk);
        model_step();
        @(negedge rdclk);
        compare_all();
    endtask

    task automatic set_word(input int ch, input logic [P-1:0] w);
        word_in[ch*P +: P] = w;
        ready_in[ch]       = 1'b1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        model_reset();
        repeat (2) @(negedge rdclk);
        compare_all();
        check("lit_reset_valid", {31'd0, bus.valid_out}, 32'd0);
        check("lit_reset_drop", {16'd0, drop_cnt}, 32'd0);
        nreset = 1'b1;
    endtask

    task automatic burst(input int start);
        for (int i = 0; i < N; i++) set_word(i, 16'(i));
        tick();
        ready_in = '0;
        for (int j = 0; j < N; j++) begin
            tick();
            check("lit_rr_valid", {31'd0, bus.valid_out}, 32'd1);
            check("lit_rr_ch", {28'd0, bus.ch_out}, (start + j) % N);
            check("lit_rr_word", {16'd0, bus.word_out}, (start + j) % N);
        end
        tick();
        check("lit_rr_idle", {31'd0, bus.valid_out}, 32'd0);
    endtask

    initial begin
        bus.ack_in = 1'b1;
        model_reset();
        do_reset();

        // single word on channel 3
        set_word(3, 16'hA5A5);
        tick();
        ready_in = '0;
        check("lit_single_lat", {31'd0, bus.valid_out}, 32'd0);
        tick();
        check("lit_single_valid", {31'd0, bus.valid_out}, 32'd1);
        check("lit_single_word", {16'd0, bus.word_out}, 32'h0000_A5A5);
        check("lit_single_ch", {28'd0, bus.ch_out}, 32'd3);
        tick();
        check("lit_single_done", {31'd0, bus.valid_out}, 32'd0);
        check("lit_single_ovf", {16'd0, overflow}, 32'd0);

        // round robin from ptr=0, again from 0, then from 5
        do_reset();
        burst(0);
        burst(0);
        set_word(4, 16'h0044);
        tick();
        ready_in = '0;
        tick();
        check("lit_ch4_grant", {28'd0, bus.ch_out}, 32'd4);
        tick();
        burst(5);

        // backpressure and overrun on channel 2
        bus.ack_in = 1'b0;
        set_word(2, 16'd1);
        tick();
        set_word(2, 16'd2);
        tick();
        set_word(2, 16'd3);
        tick();
        ready_in = '0;
        check("lit_bp_word", {16'd0, bus.word_out}, 32'd1);
        check("lit_bp_ovf", {16'd0, overflow}, 32'h0000_0004);
        check("lit_bp_drop", {16'd0, drop_cnt}, 32'd1);
        bus.ack_in = 1'b1;
        tick();
        check("lit_bp_word2", {16'd0, bus.word_out}, 32'd2);
        tick();
        check("lit_bp_idle", {31'd0, bus.valid_out}, 32'd0);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        check("lit_clr_ovf", {16'd0, overflow}, 32'd0);
        check("lit_clr_drop", {16'd0, drop_cnt}, 32'd0);

        // same-edge capture and grant on channel 7
        bus.ack_in = 1'b0;
        set_word(7, 16'h0070);
        tick();
        set_word(7, 16'h0071);
        tick();
        ready_in = '0;
        check("lit_se_word", {16'd0, bus.word_out}, 32'h0070);
        check("lit_se_ovf", {16'd0, overflow}, 32'd0);
        bus.ack_in = 1'b1;
        tick();
        check("lit_se_word2", {16'd0, bus.word_out}, 32'h0071);
        tick();

        // en=0 hold: ch5 in flight, ch1 and ch9 pending, ptr=6
        bus.ack_in = 1'b0;
        set_word(5, 16'h0055);
        tick();
        ready_in = '0;
        set_word(1, 16'h0011);
        set_word(9, 16'h0099);
        tick();
        ready_in = '0;
        check("lit_en_ch5", {28'd0, bus.ch_out}, 32'd5);
        en = 1'b0;
        bus.ack_in = 1'b1;
        set_word(4, 16'h0044);
        tick();
        ready_in = '0;
        check("lit_en_done", {31'd0, bus.valid_out}, 32'd0);
        tick();
        check("lit_en_hold", {31'd0, bus.valid_out}, 32'd0);
        en = 1'b1;
        tick();
        check("lit_en_ch9", {28'd0, bus.ch_out}, 32'd9);
        check("lit_en_w9", {16'd0, bus.word_out}, 32'h0099);
        tick();
        check("lit_en_ch1", {28'd0, bus.ch_out}, 32'd1);
        tick();
        check("lit_en_idle", {31'd0, bus.valid_out}, 32'd0);
        check("lit_en_ovf", {16'd0, overflow}, 32'd0);

        // saturation on channel 6, then async reset while FULL
        bus.ack_in = 1'b0;
        set_word(6, 16'h0066);
        repeat (70003) tick();
        ready_in = '0;
        check("lit_sat_drop", {16'd0, drop_cnt}, 32'h0000_FFFF);
        check("lit_sat_ovf", {16'd0, overflow}, 32'h0000_0040);
        check("lit_sat_valid", {31'd0, bus.valid_out}, 32'd1);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        check("lit_async_valid", {31'd0, bus.valid_out}, 32'd0);
        check("lit_async_drop", {16'd0, drop_cnt}, 32'd0);
        @(negedge rdclk);
        compare_all();
        nreset = 1'b1;
        bus.ack_in = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
